fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 8 +
 rtl/fifo_rd_skid.sv | 50 +++++
 rtl/fifo_rd_stream.sv | 64 ++++++
 tb/tb_fifo_rd_stream.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side streaming adapter.
// Default word/counter widths and the depth of the output skid buffer.
package fifo_rd_stream_pkg;
  localparam int DEF_RAM_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int BUF_DEPTH     = 2;
  localparam int OCC_W         = $clog2(BUF_DEPTH + 1);
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer: entry 0 is always the head.
// Entry 0 only changes on a pop or on a push into an empty buffer, so the head is stable under stall.
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int W = DEF_RAM_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic [OCC_W-1:0] occ_o
);
  logic [W-1:0]     ent0_q, ent0_d;
  logic [W-1:0]     ent1_q, ent1_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Pop is applied first so a simultaneous push lands in the slot just freed.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    if (pop_i && (occ_q != '0)) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 1'b1;
    end
    if (push_i) begin
      if (occ_d == '0) ent0_d = push_data_i;
      else             ent1_d = push_data_i;
      occ_d = occ_d + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o = ent0_q;
  assign occ_o  = occ_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a FIFO read port (1-cycle read latency) into a valid/ready stream.
// Handshake: a word moves when out_valid && out_ready at an r_clk edge; out_data holds while stalled.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int RAM_WIDTH = DEF_RAM_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 fifo_empty,
  input  logic [RAM_WIDTH-1:0] fifo_data,
  output logic                 fifo_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RAM_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] rd_count
);
  logic                 in_flight_q, in_flight_d;
  logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
  logic [OCC_W-1:0]     occ;
  logic [OCC_W:0]       credit_used;
  logic                 out_fire;
  logic                 pop_acc;
  logic                 capture;

  assign out_valid = (occ != '0);
  assign out_fire  = out_valid & out_ready;

  // Slots committed after this edge: buffered + returning - leaving. A pop is only
  // issued when that leaves room, so returning data always finds a free slot.
  assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, in_flight_q}
                     - {{OCC_W{1'b0}}, out_fire};
  assign fifo_req    = ~r_rst & ~fifo_empty & (credit_used < (OCC_W+1)'(BUF_DEPTH));
  assign pop_acc     = fifo_req & ~fifo_empty;
  assign capture     = in_flight_q & ~r_rst;

  always_comb begin
    in_flight_d = pop_acc;
    rd_count_d  = rd_count_q + CNT_WIDTH'(out_fire);
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      in_flight_q <= 1'b0;
      rd_count_q  <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      rd_count_q  <= rd_count_d;
    end
  end

  fifo_rd_skid #(.W(RAM_WIDTH)) u_skid (
    .clk_i       (r_clk),
    .rst_i       (r_rst),
    .push_i      (capture),
    .push_data_i (fifo_data),
    .pop_i       (out_fire),
    .head_o      (out_data),
    .occ_o       (occ)
  );

  assign rd_count = rd_count_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO source, per-scenario tasks with inline checks.
module tb_fifo_rd_stream;
  localparam int W  = 8;
  localparam int CW = 16;

  logic          r_clk = 1'b0;
  logic          r_rst = 1'b1;
  logic          out_ready = 1'b0;
  logic          empty_mask = 1'b1;
  logic          fifo_empty;
  logic          fifo_req;
  logic          out_valid;
  logic [W-1:0]  fifo_data = '0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] rd_count;

  logic [W-1:0]  src_mem [0:255];
  int            src_wr = 0;
  int            src_rd = 0;
  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 r_clk = ~r_clk;

  // Source FIFO: data appears the cycle after an accepted pop.
  assign fifo_empty = (src_rd == src_wr) || empty_mask;
  always @(posedge r_clk) begin
    if (fifo_req && !fifo_empty) begin
      fifo_data <= src_mem[src_rd[7:0]];
      src_rd    <= src_rd + 1;
    end
  end

  fifo_rd_stream #(.RAM_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_req   (fifo_req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .rd_count   (rd_count)
  );

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] w);
    src_mem[src_wr[7:0]] = w;
    src_wr = src_wr + 1;
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    tick();
    r_rst = 1'b1;
    out_ready = 1'b0;
    empty_mask = 1'b1;
    tick();
    src_wr = src_rd;
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset();
    logic [W-1:0] w;
    do_reset();
    load(8'hA5);
    empty_mask = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge r_clk);
      n_checks++;
      if (fifo_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b expected 0", fifo_req); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", out_valid); end
      n_checks++;
      if (rd_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0h expected 0", rd_count); end
      n_checks++;
      if (out_data !== '0) begin n_fail++; $display("FAIL rst_data: got %0h expected 0", out_data); end
      tick();
    end
    r_rst = 1'b0;
    @(negedge r_clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid: got %0b expected 0", out_valid); end
    n_checks++;
    if (fifo_req !== 1'b1) begin n_fail++; $display("FAIL post_rst_req: got %0b expected 1", fifo_req); end
    tick();
    tick();
    @(negedge r_clk);
    w = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_latency: got valid %0b expected 1", out_valid); end
    n_checks++;
    if (out_data !== w) begin n_fail++; $display("FAIL first_data: got %0h expected %0h", out_data, w); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge r_clk);
    n_checks++;
    if (rd_count !== 16'd1) begin n_fail++; $display("FAIL first_count: got %0d expected 1", rd_count); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_drain: got %0b expected 0", out_valid); end
  endtask

  task automatic test_three_words();
    logic [5:0]   exp_pop = 6'b000111;
    logic [5:0]   exp_vld = 6'b011100;
    logic [W-1:0] w;
    do_reset();
    load(8'h11); load(8'h22); load(8'h33);
    empty_mask = 1'b0;
    out_ready = 1'b1;
    tick();
    r_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge r_clk);
      n_checks++;
      if ((fifo_req && !fifo_empty) !== exp_pop[k]) begin
        n_fail++; $display("FAIL three_pop[%0d]: got %0b expected %0b", k, fifo_req && !fifo_empty, exp_pop[k]);
      end
      n_checks++;
      if (out_valid !== exp_vld[k]) begin
        n_fail++; $display("FAIL three_valid[%0d]: got %0b expected %0b", k, out_valid, exp_vld[k]);
      end
      if (exp_vld[k]) begin
        w = exp_q.pop_front();
        n_checks++;
        if (out_data !== w) begin n_fail++; $display("FAIL three_data[%0d]: got %0h expected %0h", k, out_data, w); end
      end
      tick();
    end
    @(negedge r_clk);
    n_checks++;
    if (rd_count !== 16'd3) begin n_fail++; $display("FAIL three_count: got %0d expected 3", rd_count); end
  endtask

  task automatic test_stall();
    int           pops;
    logic [W-1:0] w;
    do_reset();
    for (int i = 0; i < 5; i++) load(8'h51 + 8'(i));
    empty_mask = 1'b0;
    tick();
    r_rst = 1'b0;
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge r_clk);
      if (fifo_req && !fifo_empty) pops++;
      if (out_valid) begin
        n_checks++;
        if (out_data !== 8'h51) begin n_fail++; $display("FAIL stall_hold[%0d]: got %0h expected 51", k, out_data); end
      end
      tick();
    end
    @(negedge r_clk);
    n_checks++;
    if (pops !== 2) begin n_fail++; $display("FAIL stall_pops: got %0d expected 2", pops); end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %0b expected 1", out_valid); end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge r_clk);
      w = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_gap[%0d]: got valid %0b expected 1", j, out_valid); end
      n_checks++;
      if (out_data !== w) begin n_fail++; $display("FAIL stall_data[%0d]: got %0h expected %0h", j, out_data, w); end
      tick();
    end
    @(negedge r_clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %0b expected 0", out_valid); end
    n_checks++;
    if (rd_count !== 16'd5) begin n_fail++; $display("FAIL stall_count: got %0d expected 5", rd_count); end
  endtask

  task automatic test_toggle_random();
    int           delivered;
    int           cyc;
    logic [W-1:0] w;
    do_reset();
    for (int i = 0; i < 24; i++) load(8'($urandom_range(0, 255)));
    tick();
    r_rst = 1'b0;
    empty_mask = 1'b0;
    delivered = 0;
    cyc = 0;
    while (delivered < 24 && cyc < 600) begin
      tick();
      empty_mask = ~empty_mask;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge r_clk);
      n_checks++;
      if (dut.occ > 2'd2) begin n_fail++; $display("FAIL toggle_occ: got %0d expected <= 2", dut.occ); end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL toggle_extra: got %0h expected no word", out_data);
        end else begin
          w = exp_q.pop_front();
          if (out_data !== w) begin n_fail++; $display("FAIL toggle_data[%0d]: got %0h expected %0h", delivered, out_data, w); end
        end
        delivered++;
      end
      cyc++;
    end
    n_checks++;
    if (delivered !== 24) begin n_fail++; $display("FAIL toggle_delivered: got %0d expected 24", delivered); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(8'h77);
    empty_mask = 1'b0;
    out_ready = 1'b1;
    tick();
    r_rst = 1'b0;
    @(negedge r_clk);
    n_checks++;
    if ((fifo_req && !fifo_empty) !== 1'b1) begin n_fail++; $display("FAIL mid_pop: got %0b expected 1", fifo_req && !fifo_empty); end
    tick();
    r_rst = 1'b1;
    @(negedge r_clk);
    n_checks++;
    if (fifo_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %0b expected 0", fifo_req); end
    tick();
    r_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge r_clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid[%0d]: got %0b expected 0", k, out_valid); end
      tick();
    end
    @(negedge r_clk);
    n_checks++;
    if (rd_count !== '0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", rd_count); end
    exp_q.delete();
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int           fires;
    int           cyc;
    int           seq;
    logic [W-1:0] w;
    do_reset();
    seq = 0;
    for (int i = 0; i < 4; i++) begin load(8'(seq)); seq++; end
    empty_mask = 1'b0;
    out_ready = 1'b1;
    tick();
    r_rst = 1'b0;
    fires = 0;
    cyc = 0;
    while (fires < 65535 && cyc < 70000) begin
      tick();
      while (src_wr - src_rd < 4) begin load(8'(seq)); seq++; end
      @(negedge r_clk);
      if (out_valid && out_ready) begin
        w = exp_q.pop_front();
        n_checks++;
        if (out_data !== w) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", fires, out_data, w); end
        fires++;
      end
      cyc++;
    end
    tick();
    out_ready = 1'b0;
    @(negedge r_clk);
    n_checks++;
    if (fires !== 65535) begin n_fail++; $display("FAIL wrap_budget: got %0d transfers expected 65535", fires); end
    n_checks++;
    if (rd_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %0h expected ffff", rd_count); end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %0b expected 1", out_valid); end
    w = exp_q.pop_front();
    n_checks++;
    if (out_data !== w) begin n_fail++; $display("FAIL wrap_last_data: got %0h expected %0h", out_data, w); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge r_clk);
    n_checks++;
    if (rd_count !== '0) begin n_fail++; $display("FAIL wrap_count: got %0h expected 0", rd_count); end
  endtask

  initial begin
    test_reset();
    test_three_words();
    test_stall();
    test_toggle_random();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
